// File: rtl/instr_encoder_fifo_pkg.sv
// Format-class codes and RV32IF opcode constants shared by the injection encoder and the ID-stage decoder.
// Classes map one-to-one onto decoder opcode classes; codes 13..15 are undefined.
package instr_encoder_fifo_pkg;

    typedef enum logic [3:0] {
        FMT_R      = 4'd0,
        FMT_I_COMP = 4'd1,
        FMT_LOAD   = 4'd2,
        FMT_JALR   = 4'd3,
        FMT_S      = 4'd4,
        FMT_B      = 4'd5,
        FMT_J      = 4'd6,
        FMT_LUI    = 4'd7,
        FMT_AUIPC  = 4'd8,
        FMT_CSR    = 4'd9,
        FMT_F      = 4'd10,
        FMT_F_LOAD = 4'd11,
        FMT_F_SAVE = 4'd12
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_COMP = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_J      = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_CSR    = 7'b1110011;
    localparam logic [6:0] OP_F      = 7'b1010011;
    localparam logic [6:0] OP_F_LOAD = 7'b0000111;
    localparam logic [6:0] OP_F_SAVE = 7'b0100111;

    // Branch and jump offsets are halfword-granular, so bit 0 must be clear.
    function automatic logic needs_even_imm(input logic [3:0] fmt);
        return (fmt == FMT_B) || (fmt == FMT_J);
    endfunction

endpackage

// File: rtl/instr_encoder_fifo_pack.sv
// Combinational packer: request fields -> 32-bit RV32IF word, zero latency, no flow control.
// Flags undefined format codes and odd branch/jump offsets as illegal.
module instr_pack
    import instr_encoder_fifo_pkg::*;
(
    input  logic [3:0]  i_fmt,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_illegal
);

    always_comb begin
        o_instr   = '0;
        o_illegal = 1'b0;
        case (i_fmt)
            FMT_R:      o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            FMT_F:      o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_F};
            FMT_I_COMP: o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I_COMP};
            FMT_LOAD:   o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
            FMT_JALR:   o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_JALR};
            FMT_CSR:    o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_CSR};
            FMT_F_LOAD: o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_F_LOAD};
            FMT_S:      o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_S};
            FMT_F_SAVE: o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_F_SAVE};
            FMT_B:      o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                   i_imm[4:1], i_imm[11], OP_B};
            FMT_J:      o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_J};
            FMT_LUI:    o_instr = {i_imm[31:12], i_rd, OP_LUI};
            FMT_AUIPC:  o_instr = {i_imm[31:12], i_rd, OP_AUIPC};
            default:    o_illegal = 1'b1;
        endcase
        if (needs_even_imm(i_fmt) && i_imm[0]) begin
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder_fifo.sv
// Instruction injection encoder: packs requests into a DEPTH-entry FIFO; output valid 1 cycle after accept into empty FIFO.
// req_ready drops when full (no bypass); illegal requests complete the handshake but are dropped and counted.
module instr_encoder_fifo
    import instr_encoder_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_fmt,
    input  logic [2:0]      req_funct3,
    input  logic [6:0]      req_funct7,
    input  logic [4:0]      req_rd,
    input  logic [4:0]      req_rs1,
    input  logic [4:0]      req_rs2,
    input  logic [31:0]     req_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            err_illegal,
    output logic [ERRW-1:0] err_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_err_illegal;
    logic [ERRW-1:0] r_err_count;

    logic [31:0]     w_instr;
    logic            w_illegal;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    instr_pack u_pack (
        .i_fmt     (req_fmt),
        .i_funct3  (req_funct3),
        .i_funct7  (req_funct7),
        .i_rd      (req_rd),
        .i_rs1     (req_rs1),
        .i_rs2     (req_rs2),
        .i_imm     (req_imm),
        .o_instr   (w_instr),
        .o_illegal (w_illegal)
    );

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = req_valid && !w_full;
    assign w_push   = w_accept && !w_illegal && !flush;
    assign w_pop    = !w_empty && out_ready && !flush;

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_instr;
        end
    end

    // Pointer arithmetic relies on DEPTH being a power of two for natural wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Error accounting survives flush; only reset clears the counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_illegal <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_err_illegal <= w_accept && w_illegal;
            if (w_accept && w_illegal && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERRW'(1);
            end
        end
    end

    assign req_ready   = !w_full;
    assign out_valid   = !w_empty;
    assign out_instr   = r_mem[r_rd_ptr];
    assign err_illegal = r_err_illegal;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_instr_encoder_fifo.sv
// Scoreboarded bench for instr_encoder_fifo: directed encodings, illegal drops, backpressure, flush, async reset.
module tb_instr_encoder_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_fmt;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err_illegal;
    logic [7:0]  err_count;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    instr_encoder_fifo #(.DEPTH(4), .ERRW(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fmt     (req_fmt),
        .req_funct3  (req_funct3),
        .req_funct7  (req_funct7),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .err_illegal (err_illegal),
        .err_count   (err_count)
    );

    // Reference encoder: bit 32 set when the request is legal.
    function automatic logic [32:0] model(input logic [3:0] f, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
        logic [31:0] w;
        logic        ok;
        ok = 1'b1;
        w  = 32'h0;
        case (f)
            4'd0:  w = {f7, rs2, rs1, f3, rd, 7'h33};
            4'd10: w = {f7, rs2, rs1, f3, rd, 7'h53};
            4'd1:  w = {imm[11:0], rs1, f3, rd, 7'h13};
            4'd2:  w = {imm[11:0], rs1, f3, rd, 7'h03};
            4'd3:  w = {imm[11:0], rs1, f3, rd, 7'h67};
            4'd9:  w = {imm[11:0], rs1, f3, rd, 7'h73};
            4'd11: w = {imm[11:0], rs1, f3, rd, 7'h07};
            4'd4:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            4'd12: w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h27};
            4'd5:  begin w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63}; ok = !imm[0]; end
            4'd6:  begin w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F}; ok = !imm[0]; end
            4'd7:  w = {imm[31:12], rd, 7'h37};
            4'd8:  w = {imm[31:12], rd, 7'h17};
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    task automatic drive_req(input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm);
        req_fmt = f; req_funct3 = f3; req_funct7 = f7;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
    endtask

    task automatic rand_req();
        logic [3:0]  f;
        logic [31:0] imm;
        f   = 4'($urandom_range(0, 12));
        imm = $urandom;
        if (f == 4'd5 || f == 4'd6) imm[0] = 1'b0;
        drive_req(f, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    endtask

    // One clock: decides at the falling edge what the coming rising edge will transfer,
    // updates the scoreboard, and returns any popped word with its expectation.
    task automatic step(output logic popped, output logic [31:0] got, output logic [31:0] want);
        logic [32:0] m;
        @(negedge clock);
        popped = 1'b0;
        got    = out_instr;
        want   = 32'hxxxxxxxx;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                popped = 1'b1;
                if (exp_q.size() > 0) want = exp_q.pop_front();
            end
            if (req_valid && req_ready) begin
                m = model(req_fmt, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm);
                if (m[32]) exp_q.push_back(m[31:0]);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag);
        logic        p;
        logic [31:0] g, w;
        req_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (out_valid || exp_q.size() > 0); i++) begin
            step(p, g, w);
            if (p) begin
                n_assert++;
                if (g !== w) begin
                    n_fail++;
                    $display("FAIL %s_drain: out_instr=%h expected %h", tag, g, w);
                end
            end
        end
        n_assert++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_empty: out_valid=%b pending=%0d expected 0/0", tag, out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        drive_req(4'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_assert++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || err_illegal !== 1'b0 || err_count !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b instr=%h ill=%b cnt=%h expected 0/0/0/0",
                     out_valid, out_instr, err_illegal, err_count);
        end
        reset = 1'b0;
        #1;
        n_assert++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b expected 1", req_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_encode();
        logic [3:0]  f  [5] = '{4'd1, 4'd4, 4'd6, 4'd7, 4'd5};
        logic [2:0]  f3 [5] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
        logic [4:0]  rd [5] = '{5'd1, 5'd0, 5'd1, 5'd5, 5'd0};
        logic [4:0]  r1 [5] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd1};
        logic [4:0]  r2 [5] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd2};
        logic [31:0] im [5] = '{32'd5, 32'd8, 32'd8, 32'h12345000, 32'd16};
        logic [31:0] k  [5] = '{32'h00500093, 32'h0020A423, 32'h008000EF, 32'h123452B7, 32'h00208863};
        logic        p;
        logic [31:0] g, w;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(f[i], f3[i], 7'd0, rd[i], r1[i], r2[i], im[i]);
            step(p, g, w);
            req_valid = 1'b0;
            n_assert++;
            if (out_valid !== 1'b1 || out_instr !== k[i] || err_illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL encode_%0d: v=%b instr=%h ill=%b expected 1/%h/0",
                         i, out_valid, out_instr, err_illegal, k[i]);
            end
            step(p, g, w);
            n_assert++;
            if (!p || g !== w) begin
                n_fail++;
                $display("FAIL encode_sb_%0d: popped=%b instr=%h expected 1/%h", i, p, g, w);
            end
        end
    endtask

    task automatic test_illegal();
        logic        p;
        logic [31:0] g, w;
        drive_req(4'd5, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd17);
        step(p, g, w);
        req_valid = 1'b0;
        n_assert++;
        if (err_illegal !== 1'b1 || err_count !== 8'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_b: ill=%b cnt=%0d v=%b expected 1/1/0", err_illegal, err_count, out_valid);
        end
        step(p, g, w);
        n_assert++;
        if (err_illegal !== 1'b0 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_pulse: ill=%b cnt=%0d expected 0/1", err_illegal, err_count);
        end
        drive_req(4'd13, 3'd0, 7'd0, 5'd3, 5'd3, 5'd3, 32'd4);
        step(p, g, w);
        req_valid = 1'b0;
        n_assert++;
        if (err_illegal !== 1'b1 || err_count !== 8'd2 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_fmt: ill=%b cnt=%0d v=%b expected 1/2/0", err_illegal, err_count, out_valid);
        end
        step(p, g, w);
    endtask

    task automatic test_back_to_back();
        logic        p;
        logic [31:0] g, w;
        logic [31:0] head;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready_%0d: req_ready=%b expected 1", i, req_ready);
            end
            rand_req();
            step(p, g, w);
        end
        req_valid = 1'b0;
        head = exp_q[0];
        n_assert++;
        if (req_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== head) begin
            n_fail++;
            $display("FAIL full: ready=%b v=%b instr=%h expected 0/1/%h", req_ready, out_valid, out_instr, head);
        end
        rand_req();
        repeat (2) step(p, g, w);
        n_assert++;
        if (out_instr !== head || exp_q.size() != 4) begin
            n_fail++;
            $display("FAIL full_hold: instr=%h pending=%0d expected %h/4", out_instr, exp_q.size(), head);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rand_req();
            step(p, g, w);
            if (p) begin
                n_assert++;
                if (g !== w) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: out_instr=%h expected %h", i, g, w);
                end
            end
        end
        drain("b2b");
    endtask

    task automatic test_flush();
        logic        p;
        logic [31:0] g, w;
        logic [7:0]  cnt;
        logic [32:0] m;
        cnt = err_count;
        out_ready = 1'b0;
        repeat (3) begin
            rand_req();
            step(p, g, w);
        end
        rand_req();
        flush = 1'b1;
        step(p, g, w);
        flush = 1'b0;
        req_valid = 1'b0;
        n_assert++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || err_count !== cnt) begin
            n_fail++;
            $display("FAIL flush: v=%b ready=%b cnt=%0d expected 0/1/%0d", out_valid, req_ready, err_count, cnt);
        end
        drive_req(4'd8, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE123);
        m = model(4'd8, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE123);
        step(p, g, w);
        req_valid = 1'b0;
        n_assert++;
        if (out_valid !== 1'b1 || out_instr !== m[31:0]) begin
            n_fail++;
            $display("FAIL flush_after: v=%b instr=%h expected 1/%h", out_valid, out_instr, m[31:0]);
        end
        drain("flush");
    endtask

    task automatic test_async_reset();
        logic        p;
        logic [31:0] g, w;
        logic [32:0] m;
        out_ready = 1'b0;
        repeat (2) begin
            rand_req();
            step(p, g, w);
        end
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        n_assert++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || err_count !== 8'h0) begin
            n_fail++;
            $display("FAIL async_reset: v=%b instr=%h cnt=%0d expected 0/0/0", out_valid, out_instr, err_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive_req(4'd0, 3'd7, 7'h20, 5'd31, 5'd17, 5'd3, 32'd0);
        m = model(4'd0, 3'd7, 7'h20, 5'd31, 5'd17, 5'd3, 32'd0);
        step(p, g, w);
        req_valid = 1'b0;
        n_assert++;
        if (out_valid !== 1'b1 || out_instr !== m[31:0]) begin
            n_fail++;
            $display("FAIL async_reset_first: v=%b instr=%h expected 1/%h", out_valid, out_instr, m[31:0]);
        end
        drain("arst");
    endtask

    initial begin
        test_reset();
        test_encode();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
